mcash_ch_req_gen: RTL and testbench

Synthesizable request initiator for one mcash channel. It drives the channel request interface (valid/allowIn/op/addr/data) and consumes the return interface (valid/ready/data). It issues a programmed burst of writes and/or reads with a deterministic data pattern, then checks every read return against that pattern. It is instantiated once per channel (ch0..ch2) in front of mcash_top for self-checking traffic in simulation and on FPGA bring-up.

---
 rtl/mcash_ch_req_gen.sv | 146 ++++++++++++++
 tb/tb_mcash_ch_req_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcash_ch_req_gen.sv
// mcash channel request initiator: issues a programmed write/read burst
// with a deterministic data pattern and checks every read return.
module mcash_ch_req_gen #(
  parameter int unsigned NUM_REQ         = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [27:0] BASE_ADDR       = 28'h0000000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [1:0]   mode_i,
  output logic         req_valid_o,
  input  logic         req_allowIn_i,
  output logic [2:0]   req_op_o,
  output logic [27:0]  req_addr_o,
  output logic [127:0] req_data_o,
  input  logic         rtn_valid_i,
  output logic         rtn_ready_o,
  input  logic [127:0] rtn_data_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [15:0]  err_cnt_o,
  output logic [27:0]  first_err_addr_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [15:0] LAST = 16'(NUM_REQ - 1);
  localparam logic [3:0]  MAXO = 4'(MAX_OUTSTANDING);

  function automatic logic [127:0] pat(input logic [27:0] a);
    logic [31:0] w;
    w = {a, 4'h0};
    return {~w, w, ~w, w};
  endfunction

  logic [2:0]  state_q, state_d;
  logic        rd_after_q, rd_after_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] rk_q, rk_d;
  logic [3:0]  out_q, out_d;
  logic [15:0] err_q, err_d;
  logic [27:0] ferr_q, ferr_d;
  logic        done_q, done_d;

  logic        in_wr, in_rd, req_hs, start_acc;
  logic        inc, dec, bad, last;
  logic [27:0] cur_addr, exp_addr, bad_addr;
  logic [15:0] err_base;
  logic [27:0] ferr_base;

  // Request side and status outputs, decoded from the current state
  always_comb begin
    in_wr       = (state_q == S_WR);
    in_rd       = (state_q == S_RD);
    cur_addr    = BASE_ADDR + 28'(idx_q);
    req_valid_o = in_wr | (in_rd & (out_q < MAXO));
    req_op_o    = in_wr ? 3'b001 : 3'b000;
    req_addr_o  = (in_wr | in_rd) ? cur_addr : 28'h0;
    req_data_o  = in_wr ? pat(cur_addr) : 128'h0;
    rtn_ready_o = 1'b1;
    busy_o      = in_wr | in_rd | (state_q == S_DRAIN);
    done_o      = done_q;
    err_cnt_o   = err_q;
    first_err_addr_o = ferr_q;
  end

  // Handshakes, return checking and next-state computation
  always_comb begin
    req_hs    = req_valid_o & req_allowIn_i;
    start_acc = start_i & (state_q == S_IDLE);
    last      = (idx_q == LAST);
    inc       = in_rd & req_hs;
    dec       = rtn_valid_i & (out_q != 4'd0);
    exp_addr  = BASE_ADDR + 28'(rk_q);
    bad       = rtn_valid_i &
                ((out_q == 4'd0) | (rtn_data_i != pat(exp_addr)));
    bad_addr  = (out_q == 4'd0) ? 28'h0 : exp_addr;

    err_base  = start_acc ? 16'h0 : err_q;
    ferr_base = start_acc ? 28'h0 : ferr_q;
    err_d     = err_base;
    ferr_d    = ferr_base;
    if (bad) begin
      if (err_base != 16'hFFFF) err_d = err_base + 16'd1;
      if (err_base == 16'h0)    ferr_d = bad_addr;
    end

    unique case ({inc, dec})
      2'b10:   out_d = out_q + 4'd1;
      2'b01:   out_d = out_q - 4'd1;
      default: out_d = out_q;
    endcase

    rk_d = start_acc ? 16'h0 : (dec ? rk_q + 16'd1 : rk_q);

    idx_d = idx_q;
    if (start_acc)   idx_d = 16'h0;
    else if (req_hs) idx_d = last ? 16'h0 : idx_q + 16'd1;

    state_d    = state_q;
    rd_after_d = rd_after_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        rd_after_d = (mode_i == 2'b10);
        state_d    = mode_i[0] ? S_RD : S_WR;
      end
      S_WR:    if (req_hs && last) state_d = rd_after_q ? S_RD : S_DONE;
      S_RD:    if (req_hs && last) state_d = S_DRAIN;
      S_DRAIN: if (out_q == 4'd0)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d = start_acc ? 1'b0 : done_q;
    if (state_d == S_DONE) done_d = 1'b1;
  end

  // State registers; reset aborts any burst in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      rd_after_q <= 1'b0;
      idx_q      <= 16'h0;
      rk_q       <= 16'h0;
      out_q      <= 4'd0;
      err_q      <= 16'h0;
      ferr_q     <= 28'h0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_after_q <= rd_after_d;
      idx_q      <= idx_d;
      rk_q       <= rk_d;
      out_q      <= out_d;
      err_q      <= err_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mcash_ch_req_gen.sv
// Directed bench for mcash_ch_req_gen: scenario table plus
// hand sequences for back-pressure, idle returns and reset.
module tb_mcash_ch_req_gen;

  localparam int NREQ = 6;
  localparam logic [27:0] BASE = 28'hFFFFFFE;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [1:0]   mode_i = 2'b00;
  logic         req_valid_o;
  logic         req_allowIn_i = 1'b1;
  logic [2:0]   req_op_o;
  logic [27:0]  req_addr_o;
  logic [127:0] req_data_o;
  logic         rtn_valid_i = 1'b0;
  logic         rtn_ready_o;
  logic [127:0] rtn_data_i = '0;
  logic         busy_o, done_o;
  logic [15:0]  err_cnt_o;
  logic [27:0]  first_err_addr_o;

  mcash_ch_req_gen #(
    .NUM_REQ(NREQ), .MAX_OUTSTANDING(4), .BASE_ADDR(BASE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .mode_i(mode_i),
    .req_valid_o(req_valid_o), .req_allowIn_i(req_allowIn_i),
    .req_op_o(req_op_o), .req_addr_o(req_addr_o),
    .req_data_o(req_data_o), .rtn_valid_i(rtn_valid_i),
    .rtn_ready_o(rtn_ready_o), .rtn_data_i(rtn_data_i),
    .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
    .first_err_addr_o(first_err_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    int          stall_at;
    int          stall_len;
    logic [7:0]  corrupt;
    int          exp_wr;
    int          exp_rd;
    logic [15:0] exp_err;
    logic [27:0] exp_first;
  } vec_t;

  typedef struct {
    logic [2:0]   op;
    logic [27:0]  addr;
    logic [127:0] data;
  } req_t;

  typedef struct {
    logic [27:0] addr;
    int          cyc;
  } pend_t;

  int nchk = 0;
  int nerr = 0;

  req_t  log_q[$];
  pend_t pend_q[$];
  int cyc = 0, hs_cnt = 0, wr_n = 0, rd_n = 0, rk = 0;
  int budget = 1000, stall_at = -1, stall_rem = 0, nwr = 0;
  logic [7:0] corrupt = '0;
  logic force_rtn = 1'b0;

  function automatic logic [127:0] pat(input logic [27:0] a);
    logic [31:0] w;
    w = {a, 4'h0};
    return {~w, w, ~w, w};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory / back-pressure model, acting on the falling edge
  always @(negedge clk) begin
    cyc++;
    rtn_valid_i = 1'b0;
    rtn_data_i  = '0;
    if (!rst_n) begin
      req_allowIn_i = 1'b1;
    end else begin
      req_allowIn_i = 1'b1;
      if (req_valid_o && hs_cnt == stall_at && stall_rem > 0) begin
        req_allowIn_i = 1'b0;
        stall_rem--;
        begin
          logic [27:0] ea;
          ea = BASE + 28'(hs_cnt < nwr ? hs_cnt : hs_cnt - nwr);
          chk("stall_addr", {100'h0, req_addr_o}, {100'h0, ea});
          chk("stall_data", req_data_o,
              (hs_cnt < nwr) ? pat(ea) : 128'h0);
        end
      end
      if (req_valid_o && req_allowIn_i) begin
        log_q.push_back('{req_op_o, req_addr_o, req_data_o});
        if (req_op_o == 3'b001) wr_n++;
        else begin
          rd_n++;
          pend_q.push_back('{req_addr_o, cyc});
        end
        hs_cnt++;
      end
      if (force_rtn) begin
        rtn_valid_i = 1'b1;
        rtn_data_i  = 128'h5A;
        force_rtn   = 1'b0;
      end else if (budget > 0 && pend_q.size() > 0 &&
                   cyc - pend_q[0].cyc >= 2) begin
        rtn_valid_i = 1'b1;
        rtn_data_i  = pat(pend_q[0].addr) ^ {127'h0, corrupt[rk[2:0]]};
        void'(pend_q.pop_front());
        rk++;
        budget--;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic env_clear(input vec_t v);
    log_q.delete();
    pend_q.delete();
    hs_cnt = 0; wr_n = 0; rd_n = 0; rk = 0;
    budget = 1000;
    corrupt = v.corrupt;
    stall_at = v.stall_at;
    stall_rem = v.stall_len;
    nwr = v.exp_wr;
  endtask

  task automatic do_start(input logic [1:0] m);
    start_i = 1'b1;
    mode_i  = m;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 300; i++) begin
      if (done_o) break;
      tick(1);
    end
    chk({nm, "_done_seen"}, {127'h0, done_o}, 128'h1);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_ctl"},
        {121'h0, req_valid_o, req_op_o, rtn_ready_o, busy_o, done_o},
        {121'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0});
    chk({nm, "_addr"}, {100'h0, req_addr_o}, 128'h0);
    chk({nm, "_data"}, req_data_o, 128'h0);
    chk({nm, "_err"}, {84'h0, err_cnt_o, first_err_addr_o}, 128'h0);
  endtask

  task automatic check_log(input string nm, input vec_t v);
    int bad;
    bad = 0;
    for (int j = 0; j < log_q.size(); j++) begin
      logic w;
      logic [27:0] ea;
      w  = (j < v.exp_wr);
      ea = BASE + 28'(w ? j : j - v.exp_wr);
      if (log_q[j].op != (w ? 3'b001 : 3'b000) ||
          log_q[j].addr != ea ||
          log_q[j].data != (w ? pat(ea) : 128'h0)) bad++;
    end
    chk({nm, "_log_len"}, 128'(log_q.size()),
        128'(v.exp_wr + v.exp_rd));
    chk({nm, "_log_bad"}, 128'(bad), 128'h0);
  endtask

  vec_t tbl[7];

  initial begin
    // mode, stall_at, stall_len, corrupt, wr, rd, err, first_err
    tbl[0] = '{2'b10, -1, 0, 8'h00, NREQ, NREQ, 16'd0, 28'h0};
    tbl[1] = '{2'b00, -1, 0, 8'h00, NREQ, 0,    16'd0, 28'h0};
    tbl[2] = '{2'b01, -1, 0, 8'h00, 0,    NREQ, 16'd0, 28'h0};
    tbl[3] = '{2'b11, -1, 0, 8'h00, 0,    NREQ, 16'd0, 28'h0};
    tbl[4] = '{2'b01, -1, 0, 8'h0A, 0,    NREQ, 16'd2, 28'hFFFFFFF};
    tbl[5] = '{2'b10,  2, 5, 8'h00, NREQ, NREQ, 16'd0, 28'h0};
    tbl[6] = '{2'b10,  8, 3, 8'h01, NREQ, NREQ, 16'd1, 28'hFFFFFFE};

    tick(3);
    check_reset("reset");
    rst_n = 1'b1;
    tick(2);

    // Return while idle with nothing outstanding
    force_rtn = 1'b1;
    tick(2);
    chk("idle_rtn_err", {112'h0, err_cnt_o}, 128'h1);
    chk("idle_rtn_addr", {100'h0, first_err_addr_o}, 128'h0);

    for (int t = 0; t < 7; t++) begin
      string nm;
      nm = $sformatf("vec%0d", t);
      env_clear(tbl[t]);
      do_start(tbl[t].mode);
      chk({nm, "_busy_on"}, {126'h0, busy_o, done_o}, 128'h2);
      chk({nm, "_err_clr"}, {112'h0, err_cnt_o}, 128'h0);
      wait_done(nm);
      chk({nm, "_busy_off"}, {127'h0, busy_o}, 128'h0);
      chk({nm, "_wr_n"}, 128'(wr_n), 128'(tbl[t].exp_wr));
      chk({nm, "_rd_n"}, 128'(rd_n), 128'(tbl[t].exp_rd));
      chk({nm, "_err"}, {112'h0, err_cnt_o}, {112'h0, tbl[t].exp_err});
      if (tbl[t].exp_err != 0)
        chk({nm, "_first"}, {100'h0, first_err_addr_o},
            {100'h0, tbl[t].exp_first});
      tick(1);
      chk({nm, "_held"}, {126'h0, busy_o, done_o}, 128'h1);
      check_log(nm, tbl[t]);
    end

    // Outstanding limit with returns withheld
    begin
      vec_t v;
      v = '{2'b01, -1, 0, 8'h00, 0, NREQ, 16'd0, 28'h0};
      env_clear(v);
      budget = 0;
      do_start(2'b01);
      tick(12);
      chk("hold_rd4", 128'(rd_n), 128'd4);
      chk("hold_valid", {126'h0, req_valid_o, busy_o}, 128'h1);
      do_start(2'b00);
      tick(2);
      chk("hold_restart_ign", {125'h0, req_op_o}, 128'h0);
      chk("hold_rd4b", 128'(rd_n), 128'd4);
      budget = 1;
      tick(6);
      chk("hold_rd5", 128'(rd_n), 128'd5);
      chk("hold_valid2", {127'h0, req_valid_o}, 128'h0);
      budget = 1000;
      wait_done("hold");
      chk("hold_rd6", 128'(rd_n), 128'd6);
      chk("hold_err", {112'h0, err_cnt_o}, 128'h0);
      tick(1);
      check_log("hold", v);
    end

    // Reset asserted in the middle of the read phase
    begin
      vec_t v;
      v = '{2'b01, -1, 0, 8'h00, 0, NREQ, 16'd0, 28'h0};
      env_clear(v);
      do_start(2'b01);
      tick(3);
      chk("mid_busy", {127'h0, busy_o}, 128'h1);
      rst_n = 1'b0;
      #1;
      check_reset("mid_rst");
      tick(2);
      env_clear(v);
      rst_n = 1'b1;
      tick(2);
      check_reset("post_rst");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
